cache_line_responder: RTL
=========================

// Module: cache_line_responder
// PURPOSE
//   Backing-memory side of the direct-mapped cache miss interface. Accepts one
//   line request at a time from the cache controller: a line fill (read) or a
//   line write-back (write). Serves it as a LineWords-beat burst after a fixed
//   access latency. Sits between the cache and main storage; the word array is
//   held internally.
// PARAMETERS
//   MemWidth        32  bits per memory word / burst beat
//   MemAddressSize  16  word-address width; array depth 2**MemAddressSize
//   LineWords        4  beats per line; power of two, >=2
//   Latency          3  idle cycles between request accept and first data/ack; >=1
// PORTS
//   clk        in   1               clock, rising edge
//   rst        in   1               synchronous reset, active-high
//   req_valid  in   1               request present
//   req_ready  out  1               responder idle, can accept
//   req_rw     in   1               0 = line fill (read), 1 = write-back
//   req_addr   in   MemAddressSize  word address within the target line
//   wdata      in   MemWidth        write-back beat data
//   wvalid     in   1               write beat valid
//   wready     out  1               write beat accepted when wvalid&&wready
//   rdata      out  MemWidth        fill beat data
//   rvalid     out  1               fill beat valid
//   rready     in   1               cache accepts fill beat
//   rlast      out  1               final beat of fill (qualified by rvalid)
//   done       out  1               1-cycle pulse: request fully complete
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1; wready=0; rvalid=0; rlast=0; done=0;
//     rdata=0. Array contents are not cleared. Reset mid-burst abandons it.
//     Write beats already committed stay written.
//   - States: IDLE, WCOLLECT, WAIT, RBURST, DONE.
//   - IDLE: req_valid&&req_ready latches rw, line base (req_addr with low
//     log2(LineWords) bits zeroed) and start offset. req_ready drops next cycle.
//     rw=0 -> WAIT. rw=1 -> WCOLLECT.
//   - WCOLLECT: wready=1. Each wvalid beat is written to base+offset on that edge.
//     The offset increments modulo LineWords. After LineWords beats -> WAIT.
//     No timeout on wvalid.
//   - WAIT: counter loads Latency-1 and counts down to 0. At 0: read -> RBURST,
//     write -> DONE.
//   - RBURST: rvalid=1 with registered rdata. The beat advances only on
//     rvalid&&rready. Under rready=0, rdata/rlast hold stable. rlast=1 on beat
//     LineWords-1. After the last handshake -> DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE with req_ready=1. Earliest
//     next accept is the cycle after done.
//   - Read latency: first rvalid is Latency+1 cycles after the accept edge.
//   - Offsets wrap within the line and never carry into the line index. The top
//     line of the array wraps to its own base, not to address 0.
//   - req_valid while busy is ignored (req_ready=0). The requester holds it.
// CONFIGURATION
//   CLR_CRITICAL_WORD_FIRST_EN
//     defined:   start offset = req_addr low bits, for both the fill order and
//                the expected write-back beat order. Wraps mod LineWords.
//     undefined: start offset is always 0. req_addr low bits are ignored.
// STRUCTURE
//   - Shared include cache_defs.vh (guarded): state encodings
//     (CLR_IDLE..CLR_DONE), RW_READ/RW_WRITE constants, clog2 helper macro.
//     These are reused by the cache controller.
//   - One sub-module: clr_word_array is a single-port synchronous RAM,
//     MemWidth x 2**MemAddressSize, one-cycle read.
//   - FSM, latency counter, beat counter and offset logic stay in the top.
// TESTING (defaults unless stated)
//   - Reset, idle: rst=1 for 2 cycles -> req_ready=1, rvalid=0, done=0,
//     wready=0.
//   - Write-back then fill: write addr 0x0010 with beats 0xA0..0xA3 -> done
//     pulse 3 cycles after the last beat. Then read 0x0010 -> rvalid 4 cycles
//     after accept, data A0,A1,A2,A3, rlast on A3.
//   - Backpressure: rready toggles 1,0,0,1 during the fill -> rdata/rlast held.
//     No beat is lost or duplicated; exactly 4 handshakes occur.
//   - Critical word (macro on): read 0x0012 -> order A2,A3,A0,A1, rlast on A1.
//     Macro off: order A0..A3.
//   - Top-of-array line 0xFFFC with macro on and addr 0xFFFF -> beats FFFF,FFFC,
//     FFFD,FFFE. There is no access to 0x0000.
//   - Reset during RBURST beat 2 -> next cycle IDLE, rvalid=0. A fresh read of
//     the same line returns the intact data.

Source files
------------

// File: rtl/cache_line_responder_pkg.sv
// Shared definitions for the cache miss interface: FSM state encodings, request
// direction constants and a clog2 helper, also used by the cache controller.
package cache_line_responder_pkg;

  localparam logic [2:0] CLR_IDLE     = 3'd0;
  localparam logic [2:0] CLR_WCOLLECT = 3'd1;
  localparam logic [2:0] CLR_WAIT     = 3'd2;
  localparam logic [2:0] CLR_RBURST   = 3'd3;
  localparam logic [2:0] CLR_DONE     = 3'd4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  function automatic int clr_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/clr_word_array.sv
// Single-port synchronous word array backing the cache line responder.
// A read returns data on the edge after the address; rdata holds while en is low.
module clr_word_array #(
  parameter int Width    = 32,
  parameter int AddrBits = 16
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [AddrBits-1:0] addr,
  input  logic [Width-1:0]    wdata,
  output logic [Width-1:0]    rdata
);

  logic [Width-1:0] mem [2**AddrBits];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_line_responder.sv
// Memory-side responder for cache line fills and write-backs with fixed latency.
// Define CLR_CRITICAL_WORD_FIRST_EN to start each burst at the requested word.
module cache_line_responder
  import cache_line_responder_pkg::*;
#(
  parameter int MemWidth       = 32,
  parameter int MemAddressSize = 16,
  parameter int LineWords      = 4,
  parameter int Latency        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rw,
  input  logic [MemAddressSize-1:0] req_addr,
  input  logic [MemWidth-1:0]       wdata,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [MemWidth-1:0]       rdata,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      rlast,
  output logic                      done
);

  localparam int OffBits  = clr_clog2(LineWords);
  localparam int LineBits = MemAddressSize - OffBits;
  localparam int CntBits  = clr_clog2(Latency) + 1;
`ifdef CLR_CRITICAL_WORD_FIRST_EN
  localparam bit CwfEn = 1'b1;
`else
  localparam bit CwfEn = 1'b0;
`endif

  logic [2:0]                state;
  logic                      rw;
  logic [LineBits-1:0]       line_idx;
  logic [OffBits-1:0]        start_off;
  logic [OffBits-1:0]        beat;
  logic [OffBits-1:0]        beat_sel;
  logic [OffBits-1:0]        word_off;
  logic [OffBits-1:0]        req_off;
  logic [CntBits-1:0]        cnt;
  logic                      ram_en;
  logic                      ram_we;
  logic [MemAddressSize-1:0] ram_addr;
  logic [MemWidth-1:0]       ram_rdata;

  assign req_off = CwfEn ? req_addr[OffBits-1:0] : '0;

  // While a beat is on the bus and being accepted, the array prefetches the next one.
  always_comb begin
    beat_sel = beat;
    if (state == CLR_RBURST && rvalid) beat_sel = beat + OffBits'(1);
  end

  assign word_off  = start_off + beat_sel;
  assign ram_addr  = {line_idx, word_off};
  assign ram_we    = !rst && (state == CLR_WCOLLECT) && wvalid;
  assign ram_en    = ram_we ||
                     (!rst && state == CLR_RBURST && (!rvalid || (rready && !rlast)));

  assign req_ready = (state == CLR_IDLE);
  assign wready    = (state == CLR_WCOLLECT);
  assign done      = (state == CLR_DONE);
  assign rlast     = rvalid && (beat == OffBits'(LineWords - 1));
  assign rdata     = rvalid ? ram_rdata : '0;

  clr_word_array #(
    .Width    (MemWidth),
    .AddrBits (MemAddressSize)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // The first RBURST cycle only fetches beat 0, giving the extra read cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLR_IDLE;
      rw        <= RW_READ;
      line_idx  <= '0;
      start_off <= '0;
      beat      <= '0;
      cnt       <= '0;
      rvalid    <= 1'b0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (req_valid) begin
            rw        <= req_rw;
            line_idx  <= req_addr[MemAddressSize-1:OffBits];
            start_off <= req_off;
            beat      <= '0;
            cnt       <= CntBits'(Latency - 1);
            state     <= (req_rw == RW_WRITE) ? CLR_WCOLLECT : CLR_WAIT;
          end
        end
        CLR_WCOLLECT: begin
          if (wvalid) begin
            beat <= beat + OffBits'(1);
            if (beat == OffBits'(LineWords - 1)) begin
              cnt   <= CntBits'(Latency - 1);
              state <= CLR_WAIT;
            end
          end
        end
        CLR_WAIT: begin
          if (cnt == '0) begin
            beat  <= '0;
            state <= (rw == RW_WRITE) ? CLR_DONE : CLR_RBURST;
          end else begin
            cnt <= cnt - CntBits'(1);
          end
        end
        CLR_RBURST: begin
          if (!rvalid) begin
            rvalid <= 1'b1;
          end else if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              state  <= CLR_DONE;
            end else begin
              beat <= beat + OffBits'(1);
            end
          end
        end
        CLR_DONE: state <= CLR_IDLE;
        default:  state <= CLR_IDLE;
      endcase
    end
  end

endmodule
